// File: rtl/eval_arbiter_pkg.sv
// Shared definitions for the evaluation arbiter: state encoding and default sizes.
package eval_arbiter_pkg;
  localparam int N_DEF = 4;  // requesters
  localparam int W_DEF = 6;  // operand bits per requester, A..F = [5]..[0]
  localparam int ID_W  = 2;  // requester index width
  localparam int CNT_W = 8;  // completed-evaluation counter width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/eval_arbiter_if.sv
// Request/result bundle between requesters and the shared evaluation unit.
interface eval_arbiter_if
  import eval_arbiter_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
);
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_vec;
  logic [N-1:0]     grant;
  logic             busy;
  logic             res_valid;
  logic             res_y;
  logic [ID_W-1:0]  res_id;
  logic [CNT_W-1:0] eval_count;

  modport master (
    output req, req_vec,
    input  grant, busy, res_valid, res_y, res_id, eval_count
  );

  modport slave (
    input  req, req_vec,
    output grant, busy, res_valid, res_y, res_id, eval_count
  );
endinterface

// File: rtl/eval_arbiter_logic_eval.sv
// Pure combinational evaluation: y = (a&b)|(c&d)|(e&f).
module logic_eval (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic e,
  input  logic f,
  output logic y
);
  assign y = (a & b) | (c & d) | (e & f);
endmodule

// File: rtl/eval_arbiter.sv
// Round-robin arbiter sharing one evaluation unit among N requesters.
// One evaluation takes IDLE -> EVAL -> DONE; all outputs are registered.
module eval_arbiter
  import eval_arbiter_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input logic           clk,
  input logic           rst,
  eval_arbiter_if.slave bus
);
  state_t                 state, state_nx;
  logic [ID_W-1:0]        ptr, win, sel;
  logic [W-1:0]           op_reg;
  logic [N-1:0][W-1:0]    vec_a;
  logic                   y;

  logic [N-1:0]           grant_q;
  logic                   busy_q, res_valid_q, res_y_q;
  logic [ID_W-1:0]        res_id_q;
  logic [CNT_W-1:0]       cnt_q;

  assign vec_a = bus.req_vec;

  logic_eval u_eval (
    .a(op_reg[5]), .b(op_reg[4]), .c(op_reg[3]),
    .d(op_reg[2]), .e(op_reg[1]), .f(op_reg[0]),
    .y(y)
  );

  // Round-robin pick: first requester at or after ptr (scan backwards so the nearest wins).
  always_comb begin
    sel = ptr;
    for (int k = N-1; k >= 0; k--)
      if (bus.req[(int'(ptr) + k) % N]) sel = ID_W'((int'(ptr) + k) % N);
  end

  // State register; reset overrides every transition.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state: only IDLE looks at requests, the rest advance unconditionally.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (|bus.req) state_nx = EVAL;
      EVAL:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath and registered outputs; operand is latched at the IDLE sample so
  // later req/req_vec changes cannot disturb the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      win         <= '0;
      op_reg      <= '0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_y_q     <= 1'b0;
      res_id_q    <= '0;
      cnt_q       <= '0;
    end else begin
      busy_q      <= (state_nx != IDLE);
      res_valid_q <= 1'b0;
      unique case (state)
        IDLE: if (|bus.req) begin
          win     <= sel;
          op_reg  <= vec_a[sel];
          grant_q <= N'(1) << sel;
        end
        EVAL: begin
          res_y_q     <= y;
          res_id_q    <= win;
          res_valid_q <= 1'b1;
        end
        DONE: begin
          grant_q <= '0;
          ptr     <= ID_W'((int'(win) + 1) % N);
          cnt_q   <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.busy       = busy_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_y      = res_y_q;
  assign bus.res_id     = res_id_q;
  assign bus.eval_count = cnt_q;
endmodule

// File: tb/tb_eval_arbiter.sv
// Directed bench for eval_arbiter with hand-computed expectations.
module tb_eval_arbiter;
  localparam int N = 4;
  localparam int W = 6;

  logic clk = 1'b0;
  logic rst;
  int   n_run = 0, n_fail = 0, exp_cnt = 0, pulses;

  eval_arbiter_if #(.N(N), .W(W)) bus ();

  eval_arbiter #(.N(N), .W(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic [W-1:0] v);
    bus.req_vec[i*W +: W] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  // Single-requester transaction; req and operand are withdrawn during EVAL.
  task automatic run_one(input string tag, input int id, input logic [W-1:0] v, input logic exp_y);
    bus.req = 4'(1 << id);
    set_vec(id, v);
    tick();                                   // EVAL
    chk({tag, "_grant_e"}, bus.grant, 1 << id);
    chk({tag, "_busy_e"}, bus.busy, 1);
    chk({tag, "_rv_e"}, bus.res_valid, 0);
    bus.req = '0;
    set_vec(id, '0);
    tick();                                   // DONE
    chk({tag, "_rv"}, bus.res_valid, 1);
    chk({tag, "_y"}, bus.res_y, exp_y);
    chk({tag, "_id"}, bus.res_id, id);
    chk({tag, "_grant_d"}, bus.grant, 1 << id);
    tick();                                   // IDLE
    exp_cnt++;
    chk({tag, "_grant_i"}, bus.grant, 0);
    chk({tag, "_rv_i"}, bus.res_valid, 0);
    chk({tag, "_busy_i"}, bus.busy, 0);
    chk({tag, "_cnt"}, bus.eval_count, exp_cnt);
  endtask

  initial begin
    bus.req     = '0;
    bus.req_vec = '0;
    rst         = 1'b1;
    tick();
    chk("rst_grant", bus.grant, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rv", bus.res_valid, 0);
    chk("rst_y", bus.res_y, 0);
    chk("rst_id", bus.res_id, 0);
    chk("rst_cnt", bus.eval_count, 0);
    do_reset();

    // single request, zero/one results, operand latch
    run_one("single", 0, 6'b110000, 1'b1);
    run_one("zero2", 2, 6'b100100, 1'b0);
    run_one("one2", 2, 6'b001100, 1'b1);
    run_one("latch1", 1, 6'b000011, 1'b1);

    // fairness: all requesting from reset
    bus.req = 4'b1111;
    set_vec(0, 6'b110000);
    set_vec(1, 6'b000000);
    set_vec(2, 6'b001100);
    set_vec(3, 6'b000000);
    do_reset();
    tick();
    chk("rr0_grant", bus.grant, 4'b0001);
    tick();
    chk("rr0_rv", bus.res_valid, 1);
    chk("rr0_id", bus.res_id, 0);
    chk("rr0_y", bus.res_y, 1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("rr_idle_grant", bus.grant, 0);
      chk("rr_idle_rv", bus.res_valid, 0);
      tick();
      chk("rr_grant", bus.grant, 1 << (i % 4));
      tick();
      chk("rr_rv", bus.res_valid, 1);
      chk("rr_id", bus.res_id, i % 4);
      chk("rr_y", bus.res_y, ((i % 4) == 0 || (i % 4) == 2) ? 1 : 0);
    end
    // ptr is now 1: requesters 0 and 3 -> 3 wins; change in DONE is ignored until IDLE
    bus.req = 4'b1001;
    set_vec(3, 6'b000011);
    tick();
    chk("skip_idle_grant", bus.grant, 0);
    chk("skip_cnt", bus.eval_count, 5);
    tick();
    chk("skip_grant", bus.grant, 4'b1000);
    bus.req = '0;
    tick();
    chk("skip_id", bus.res_id, 3);
    chk("skip_y", bus.res_y, 1);
    tick();
    chk("skip_cnt2", bus.eval_count, 6);

    // reset during EVAL aborts
    do_reset();
    bus.req = 4'b0001;
    set_vec(0, 6'b110000);
    tick();
    chk("abort_grant_e", bus.grant, 4'b0001);
    rst = 1'b1;
    bus.req = '0;
    tick();
    chk("abort_grant", bus.grant, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_rv", bus.res_valid, 0);
    chk("abort_cnt", bus.eval_count, 0);
    rst = 1'b0;
    tick();
    chk("abort_rv2", bus.res_valid, 0);
    chk("abort_cnt2", bus.eval_count, 0);

    // counter wrap after 256 evaluations
    do_reset();
    bus.req = 4'b0001;
    pulses = 0;
    for (int c = 0; c < 1200 && pulses < 256; c++) begin
      tick();
      if (bus.res_valid) begin
        pulses++;
        if (pulses == 256) bus.req = '0;
        if (pulses == 255) begin
          tick();
          chk("cnt_255", bus.eval_count, 255);
        end else if (pulses == 256) begin
          tick();
          chk("cnt_wrap", bus.eval_count, 0);
        end
      end
    end
    chk("wrap_pulses", pulses, 256);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
